// File: rtl/bpc_fifo_arbiter.sv
// bpc_fifo_arbiter
// Round-robin read scheduler for the ten bit-plane-coder lane FIFOs that feed
// the MQ coder. It grants at most one non-empty lane per cycle, skips empty
// lanes, and limits each lane to BURST consecutive reads before it rotates.
// It returns the read word with a valid strobe and lane tag, and it signals
// when the codeblock has fully drained.
//
// Optional feature: define ARB_LANE_MASK_EN to add the lane_mask input.
//   Masked lanes are never read.
//   Masked lanes are ignored by the drain check.
//
// Ports (all in the clk_rd domain):
//   clk_rd, rst_syn   clock and synchronous active-high reset
//   start             pulse that begins a codeblock (IDLE/DONE only)
//   halt_to_fifo      level; upstream has written its last word
//   stop_rd           MQ back-pressure; blocks new reads only
//   rdempty           per-lane FIFO empty flags
//   fifo_dout         lane i word on [i*DW +: DW], valid the cycle after its read
//   lane_mask         per-lane enable (ARB_LANE_MASK_EN only)
//   rd_vld            one-hot (or zero) FIFO read enables
//   cx_d/cx_vld/cx_lane  registered word, valid strobe and lane tag
//   busy              FSM in RUN or FLUSH
//   cb_done           one-cycle pulse after the codeblock has drained
//   state_dbg/ptr_dbg/cnt_dbg  FSM state, grant pointer and burst counter
//
// Flow control: cx_vld has no ready. The consumer takes every word that is
// presented with cx_vld. stop_rd is the only flow control, and it gates only
// new reads. Up to two words that were read before stop_rd rose still emerge.
module bpc_fifo_arbiter #(
    parameter int N_LANE = 10,
    parameter int DW     = 8,
    parameter int BURST  = 4
) (
    input  logic                 clk_rd,
    input  logic                 rst_syn,
    input  logic                 start,
    input  logic                 halt_to_fifo,
    input  logic                 stop_rd,
    input  logic [N_LANE-1:0]    rdempty,
    input  logic [N_LANE*DW-1:0] fifo_dout,
`ifdef ARB_LANE_MASK_EN
    input  logic [N_LANE-1:0]    lane_mask,
`endif
    output logic [N_LANE-1:0]    rd_vld,
    output logic [DW-1:0]        cx_d,
    output logic                 cx_vld,
    output logic [3:0]           cx_lane,
    output logic                 busy,
    output logic                 cb_done,
    output logic [1:0]           state_dbg,
    output logic [3:0]           ptr_dbg,
    output logic [3:0]           cnt_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [3:0]        ptr, cnt;
    logic [N_LANE-1:0] eligible, drained;
    logic [N_LANE-1:0] rd_vld_d1;
    logic [3:0]        lane_d1;
    logic [3:0]        grant, search;
    logic              found, stay, any_elig, rd_en, rd_pend;
    logic [DW-1:0]     sel_word;

`ifdef ARB_LANE_MASK_EN
    assign eligible = ~rdempty & lane_mask;
    assign drained  = rdempty | ~lane_mask;
`else
    assign eligible = ~rdempty;
    assign drained  = rdempty;
`endif

    // Lane (p + k) modulo N_LANE for k in 1..N_LANE. Indices N_LANE..15
    // are never produced.
    function automatic logic [3:0] lane_add(input logic [3:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_LANE) s = s - N_LANE;
        return s[3:0];
    endfunction

    assign any_elig = |eligible;
    assign stay     = eligible[ptr] && (cnt < 4'(BURST));
    assign rd_pend  = |rd_vld_d1;

    // First eligible lane after ptr. Offset N_LANE is ptr itself, so a lane
    // whose burst has expired is granted again when it is the only
    // eligible lane.
    always_comb begin
        search = ptr;
        found  = 1'b0;
        for (int k = 1; k <= N_LANE; k++) begin
            if (!found && eligible[lane_add(ptr, k)]) begin
                found  = 1'b1;
                search = lane_add(ptr, k);
            end
        end
    end

    assign grant = stay ? ptr : search;
    assign rd_en = ((state == S_RUN) || (state == S_FLUSH)) && !stop_rd && any_elig;

    always_comb begin
        rd_vld = '0;
        for (int i = 0; i < N_LANE; i++) begin
            rd_vld[i] = rd_en && (grant == 4'(i));
        end
    end

    // Word returned by the lane that was read in the previous cycle.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_LANE; i++) begin
            if (rd_vld_d1[i]) sel_word = fifo_dout[i*DW +: DW];
        end
    end

    // The drain check ignores a word that sits in the output register this
    // cycle, because that word is delivered now. The DONE cycle is the first
    // cycle with nothing left to emit.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (halt_to_fifo) state_next = S_FLUSH;
            S_FLUSH: if ((&drained) && !rd_pend) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_rd) begin
        if (rst_syn) begin
            state     <= S_IDLE;
            ptr       <= 4'd0;
            cnt       <= 4'd0;
            rd_vld_d1 <= '0;
            lane_d1   <= 4'd0;
            cx_d      <= '0;
            cx_vld    <= 1'b0;
            cx_lane   <= 4'd0;
        end else begin
            state <= state_next;
            // ptr and cnt hold whenever no read is issued. After a stall,
            // reading resumes on the same lane with the same remaining burst.
            if (rd_en) begin
                ptr <= grant;
                cnt <= stay ? (cnt + 4'd1) : 4'd1;
            end
            rd_vld_d1 <= rd_vld;
            lane_d1   <= grant;
            cx_vld    <= rd_pend;
            if (rd_pend) begin
                cx_d    <= sel_word;
                cx_lane <= lane_d1;
            end
        end
    end

    assign busy      = (state == S_RUN) || (state == S_FLUSH);
    assign cb_done   = (state == S_DONE);
    assign state_dbg = state;
    assign ptr_dbg   = ptr;
    assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_bpc_fifo_arbiter.sv
// Directed bench for bpc_fifo_arbiter. A behavioural model of the ten lane
// FIFOs gives the contents. The expected grant schedules and data words are
// worked out by hand for each scenario.
module tb_bpc_fifo_arbiter;
    localparam int N_LANE = 10;
    localparam int DW     = 8;
    localparam int BURST  = 4;

    // ---------------- clock / reset ----------------
    logic clk_rd = 1'b0;
    always #5 clk_rd = ~clk_rd;

    logic                 rst_syn, start, halt_to_fifo, stop_rd;
    logic [N_LANE-1:0]    rdempty;
    logic [N_LANE*DW-1:0] fifo_dout;
    logic [N_LANE-1:0]    lane_mask;
    logic [N_LANE-1:0]    rd_vld;
    logic [DW-1:0]        cx_d;
    logic                 cx_vld, busy, cb_done;
    logic [3:0]           cx_lane, ptr_dbg, cnt_dbg;
    logic [1:0]           state_dbg;

    int checks   = 0;
    int failures = 0;

    bpc_fifo_arbiter #(.N_LANE(N_LANE), .DW(DW), .BURST(BURST)) dut (
        .clk_rd       (clk_rd),
        .rst_syn      (rst_syn),
        .start        (start),
        .halt_to_fifo (halt_to_fifo),
        .stop_rd      (stop_rd),
        .rdempty      (rdempty),
        .fifo_dout    (fifo_dout),
`ifdef ARB_LANE_MASK_EN
        .lane_mask    (lane_mask),
`endif
        .rd_vld       (rd_vld),
        .cx_d         (cx_d),
        .cx_vld       (cx_vld),
        .cx_lane      (cx_lane),
        .busy         (busy),
        .cb_done      (cb_done),
        .state_dbg    (state_dbg),
        .ptr_dbg      (ptr_dbg),
        .cnt_dbg      (cnt_dbg)
    );

    // ---------------- lane FIFO model ----------------
    int            fcnt [N_LANE];
    int            frd  [N_LANE];
    logic [DW-1:0] dout_r [N_LANE];
    logic          model_clr, load_stb;
    int            load_lane, load_n;

    function automatic logic [DW-1:0] word(input int lane, input int seq);
        return 8'(lane * 16 + (seq % 16));
    endfunction

    function automatic logic [N_LANE-1:0] onehot(input int l);
        logic [N_LANE-1:0] v;
        v = '0;
        if (l >= 0) v[l] = 1'b1;
        return v;
    endfunction

    always @(posedge clk_rd) begin
        for (int i = 0; i < N_LANE; i++) begin
            if (model_clr) begin
                fcnt[i]   <= 0;
                frd[i]    <= 0;
                dout_r[i] <= '0;
            end else if (load_stb && load_lane == i) begin
                fcnt[i] <= fcnt[i] + load_n;
            end else if (rd_vld[i] && fcnt[i] > 0) begin
                dout_r[i] <= word(i, frd[i]);
                fcnt[i]   <= fcnt[i] - 1;
                frd[i]    <= frd[i] + 1;
            end
        end
    end

    always_comb begin
        rdempty   = '0;
        fifo_dout = '0;
        for (int i = 0; i < N_LANE; i++) begin
            rdempty[i]              = (fcnt[i] == 0);
            fifo_dout[i*DW +: DW]   = dout_r[i];
        end
    end

    // ---------------- driver tasks ----------------
    // Every task starts and ends 1 time unit after a rising edge.
    task automatic apply_reset();
        rst_syn = 1'b1; model_clr = 1'b1;
        start = 1'b0; halt_to_fifo = 1'b0; stop_rd = 1'b0;
        @(posedge clk_rd); #1;
        @(posedge clk_rd); #1;
        rst_syn = 1'b0; model_clr = 1'b0;
    endtask

    task automatic load(input int lane, input int n);
        load_lane = lane; load_n = n; load_stb = 1'b1;
        @(posedge clk_rd); #1;
        load_stb = 1'b0;
    endtask

    task automatic pulse_start(input logic with_halt);
        start = 1'b1; halt_to_fifo = with_halt;
        @(posedge clk_rd); #1;
        start = 1'b0;
    endtask

    task automatic end_cb(output bit seen, output logic busy_at);
        seen = 1'b0; busy_at = 1'b1; halt_to_fifo = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_rd);
            if (!seen && cb_done === 1'b1) begin
                seen = 1'b1; busy_at = busy;
            end
            @(posedge clk_rd); #1;
            if (seen) break;
        end
        halt_to_fifo = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk_rd);
        checks++; if (rd_vld !== 10'h000) begin failures++; $display("FAIL reset_rd_vld got=%h exp=000", rd_vld); end
        checks++; if (cx_d !== 8'h00) begin failures++; $display("FAIL reset_cx_d got=%h exp=00", cx_d); end
        checks++; if (cx_vld !== 1'b0) begin failures++; $display("FAIL reset_cx_vld got=%b exp=0", cx_vld); end
        checks++; if (cx_lane !== 4'd0) begin failures++; $display("FAIL reset_cx_lane got=%0d exp=0", cx_lane); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (cb_done !== 1'b0) begin failures++; $display("FAIL reset_cb_done got=%b exp=0", cb_done); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        checks++; if (ptr_dbg !== 4'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", ptr_dbg); end
        checks++; if (cnt_dbg !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_dbg); end
        @(posedge clk_rd); #1;
    endtask

    task automatic test_single_lane();
        bit seen; logic busy_at;
        apply_reset();
        load(3, 6);
        pulse_start(1'b0);
        for (int c = 0; c < 12; c++) begin
            int rl, cl;
            rl = (c < 6) ? 3 : -1;
            cl = (c >= 2 && c < 8) ? 3 : -1;
            @(negedge clk_rd);
            checks++; if (rd_vld !== onehot(rl)) begin failures++; $display("FAIL single_rd_vld c=%0d got=%h exp=%h", c, rd_vld, onehot(rl)); end
            checks++; if (cx_vld !== (cl >= 0)) begin failures++; $display("FAIL single_cx_vld c=%0d got=%b exp=%b", c, cx_vld, (cl >= 0)); end
            if (cl >= 0) begin
                checks++; if (cx_lane !== 4'(cl)) begin failures++; $display("FAIL single_cx_lane c=%0d got=%0d exp=%0d", c, cx_lane, cl); end
                checks++; if (cx_d !== word(cl, c - 2)) begin failures++; $display("FAIL single_cx_d c=%0d got=%h exp=%h", c, cx_d, word(cl, c - 2)); end
            end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy c=%0d got=%b exp=1", c, busy); end
            @(posedge clk_rd); #1;
        end
        end_cb(seen, busy_at);
        checks++; if (!seen) begin failures++; $display("FAIL single_cb_done got=0 exp=1"); end
    endtask

    task automatic test_burst_rotation();
        bit seen; logic busy_at;
        apply_reset();
        load(0, 8);
        load(9, 8);
        pulse_start(1'b0);
        for (int c = 0; c < 20; c++) begin
            int rl, cl, cs;
            rl = (c < 16) ? ((((c / 4) % 2) == 1) ? 9 : 0) : -1;
            cl = (c >= 2 && c < 18) ? (((((c - 2) / 4) % 2) == 1) ? 9 : 0) : -1;
            cs = ((c - 2) / 8) * 4 + (c - 2) % 4;
            @(negedge clk_rd);
            checks++; if (rd_vld !== onehot(rl)) begin failures++; $display("FAIL burst_rd_vld c=%0d got=%h exp=%h", c, rd_vld, onehot(rl)); end
            checks++; if (cx_vld !== (cl >= 0)) begin failures++; $display("FAIL burst_cx_vld c=%0d got=%b exp=%b", c, cx_vld, (cl >= 0)); end
            if (cl >= 0) begin
                checks++; if (cx_lane !== 4'(cl)) begin failures++; $display("FAIL burst_cx_lane c=%0d got=%0d exp=%0d", c, cx_lane, cl); end
                checks++; if (cx_d !== word(cl, cs)) begin failures++; $display("FAIL burst_cx_d c=%0d got=%h exp=%h", c, cx_d, word(cl, cs)); end
            end
            @(posedge clk_rd); #1;
        end
        end_cb(seen, busy_at);
        checks++; if (!seen) begin failures++; $display("FAIL burst_cb_done got=0 exp=1"); end
    endtask

    task automatic test_back_pressure();
        bit seen; logic busy_at;
        int tl [21] = '{2, 2, -1, -1, -1, -1, -1, 2, 2, 5, 5, 5, 5, 2, 2, 2, 2, -1, -1, -1, -1};
        int ts [21] = '{0, 1, 0, 0, 0, 0, 0, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0};
        apply_reset();
        load(2, 8);
        load(5, 4);
        pulse_start(1'b0);
        for (int c = 0; c < 21; c++) begin
            int cl, cs;
            cl = (c >= 2) ? tl[c - 2] : -1;
            cs = (c >= 2) ? ts[c - 2] : 0;
            stop_rd = (c >= 2 && c < 7);
            @(negedge clk_rd);
            checks++; if (rd_vld !== onehot(tl[c])) begin failures++; $display("FAIL bp_rd_vld c=%0d got=%h exp=%h", c, rd_vld, onehot(tl[c])); end
            checks++; if (cx_vld !== (cl >= 0)) begin failures++; $display("FAIL bp_cx_vld c=%0d got=%b exp=%b", c, cx_vld, (cl >= 0)); end
            if (cl >= 0) begin
                checks++; if (cx_lane !== 4'(cl)) begin failures++; $display("FAIL bp_cx_lane c=%0d got=%0d exp=%0d", c, cx_lane, cl); end
                checks++; if (cx_d !== word(cl, cs)) begin failures++; $display("FAIL bp_cx_d c=%0d got=%h exp=%h", c, cx_d, word(cl, cs)); end
            end
            if (stop_rd) begin
                checks++; if (ptr_dbg !== 4'd2 || cnt_dbg !== 4'd2) begin failures++; $display("FAIL bp_freeze c=%0d got=%0d/%0d exp=2/2", c, ptr_dbg, cnt_dbg); end
            end
            @(posedge clk_rd); #1;
        end
        stop_rd = 1'b0;
        end_cb(seen, busy_at);
        checks++; if (!seen) begin failures++; $display("FAIL bp_cb_done got=0 exp=1"); end
    endtask

    task automatic test_drain_done();
        int tl [8] = '{1, 5, 7, -1, -1, -1, -1, -1};
        logic [1:0] st [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0};
        apply_reset();
        load(1, 1);
        load(5, 1);
        load(7, 1);
        pulse_start(1'b1);
        for (int c = 0; c < 8; c++) begin
            int cl;
            cl = (c >= 2) ? tl[c - 2] : -1;
            @(negedge clk_rd);
            checks++; if (rd_vld !== onehot(tl[c])) begin failures++; $display("FAIL drain_rd_vld c=%0d got=%h exp=%h", c, rd_vld, onehot(tl[c])); end
            checks++; if (cx_vld !== (cl >= 0)) begin failures++; $display("FAIL drain_cx_vld c=%0d got=%b exp=%b", c, cx_vld, (cl >= 0)); end
            if (cl >= 0) begin
                checks++; if (cx_lane !== 4'(cl)) begin failures++; $display("FAIL drain_cx_lane c=%0d got=%0d exp=%0d", c, cx_lane, cl); end
                checks++; if (cx_d !== word(cl, 0)) begin failures++; $display("FAIL drain_cx_d c=%0d got=%h exp=%h", c, cx_d, word(cl, 0)); end
            end
            checks++; if (cb_done !== (c == 5)) begin failures++; $display("FAIL drain_cb_done c=%0d got=%b exp=%b", c, cb_done, (c == 5)); end
            checks++; if (busy !== (c < 5)) begin failures++; $display("FAIL drain_busy c=%0d got=%b exp=%b", c, busy, (c < 5)); end
            checks++; if (state_dbg !== st[c]) begin failures++; $display("FAIL drain_state c=%0d got=%0d exp=%0d", c, state_dbg, st[c]); end
            @(posedge clk_rd); #1;
        end
        halt_to_fifo = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit seen; logic busy_at;
        apply_reset();
        load(6, 8);
        pulse_start(1'b0);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rst_syn = 1'b1;
            @(negedge clk_rd);
            checks++; if (rd_vld !== 10'h040) begin failures++; $display("FAIL rstmid_rd_vld c=%0d got=%h exp=040", c, rd_vld); end
            @(posedge clk_rd); #1;
        end
        rst_syn = 1'b0;
        @(negedge clk_rd);
        checks++; if (rd_vld !== 10'h000) begin failures++; $display("FAIL rstmid_rd_vld_after got=%h exp=000", rd_vld); end
        checks++; if (cx_vld !== 1'b0) begin failures++; $display("FAIL rstmid_cx_vld got=%b exp=0", cx_vld); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", state_dbg); end
        checks++; if (ptr_dbg !== 4'd0) begin failures++; $display("FAIL rstmid_ptr got=%0d exp=0", ptr_dbg); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(posedge clk_rd); #1;
        @(negedge clk_rd);
        checks++; if (cx_vld !== 1'b0) begin failures++; $display("FAIL rstmid_cx_vld_late got=%b exp=0", cx_vld); end
        @(posedge clk_rd); #1;
        // Three words left lane 6 before the reset took effect.
        pulse_start(1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_rd);
            checks++; if (rd_vld !== 10'h040) begin failures++; $display("FAIL rstmid_restart_rd c=%0d got=%h exp=040", c, rd_vld); end
            if (c == 2) begin
                checks++; if (cx_vld !== 1'b1 || cx_lane !== 4'd6) begin failures++; $display("FAIL rstmid_restart_cx got=%b/%0d exp=1/6", cx_vld, cx_lane); end
                checks++; if (cx_d !== word(6, 3)) begin failures++; $display("FAIL rstmid_restart_cx_d got=%h exp=%h", cx_d, word(6, 3)); end
            end
            @(posedge clk_rd); #1;
        end
        end_cb(seen, busy_at);
        checks++; if (!seen || busy_at !== 1'b0) begin failures++; $display("FAIL rstmid_cb_done got=%b/%b exp=1/0", seen, busy_at); end
    endtask

`ifdef ARB_LANE_MASK_EN
    task automatic test_mask();
        int  n4;
        bit  bad, seen;
        int  lane0_left;
        apply_reset();
        lane_mask = 10'h3FE;
        load(0, 2);
        load(4, 3);
        pulse_start(1'b1);
        n4 = 0; bad = 1'b0; seen = 1'b0; lane0_left = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_rd);
            if (rd_vld == 10'h010) n4++;
            else if (rd_vld !== 10'h000) bad = 1'b1;
            if (cb_done === 1'b1 && !seen) begin seen = 1'b1; lane0_left = fcnt[0]; end
            @(posedge clk_rd); #1;
        end
        halt_to_fifo = 1'b0;
        checks++; if (bad) begin failures++; $display("FAIL mask_other_lane got=1 exp=0"); end
        checks++; if (n4 != 3) begin failures++; $display("FAIL mask_lane4_reads got=%0d exp=3", n4); end
        checks++; if (!seen || lane0_left != 2) begin failures++; $display("FAIL mask_cb_done got=%b/%0d exp=1/2", seen, lane0_left); end
        lane_mask = 10'h3FF;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst_syn = 1'b1; model_clr = 1'b1; load_stb = 1'b0;
        load_lane = 0; load_n = 0; lane_mask = 10'h3FF;
        start = 1'b0; halt_to_fifo = 1'b0; stop_rd = 1'b0;
        @(posedge clk_rd); #1;
        test_reset();
        test_single_lane();
        test_burst_rotation();
        test_back_pressure();
        test_drain_done();
        test_reset_mid_run();
`ifdef ARB_LANE_MASK_EN
        test_mask();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
